tm1638_key_reader: RTL and testbench

//  Read side of the TM1638 serial link: issues the key-scan read command (0x42), releases DIO,

---
 rtl/tm1638_key_reader_pkg.sv | 38 +++
 rtl/tm1638_half_tick.sv | 29 ++
 rtl/tm1638_key_reader.sv | 188 ++++++++++++++++++
 tb/tb_tm1638_key_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_key_reader_pkg.sv
// Shared TM1638 constants, link defaults, FSM state encoding and the K3-row key decode
// used by the TM1638 read and display blocks.
package tm1638_key_reader_pkg;

  localparam int DEF_CLOCK_MAX   = 20_000_000;
  localparam int DEF_CLOCK_SPEED = 300_000;
  localparam int DEF_WAIT_CYCLES = 20;

  localparam logic [7:0] CMD_READ_KEYS   = 8'h42;
  localparam logic [7:0] CMD_WRITE_AUTO  = 8'h40;
  localparam logic [7:0] CMD_WRITE_FIXED = 8'h44;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'h88;

  localparam int CMD_BITS  = 8;
  localparam int SCAN_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STB_SETUP,
    ST_CMD,
    ST_WAIT,
    ST_READ,
    ST_END,
    ST_GAP
  } state_t;

  // The 8-key board wires its keys to K3 only: bit 0 and bit 4 of every scan byte.
  function automatic logic [7:0] decode_keys(input logic [SCAN_BITS-1:0] scan);
    logic [7:0] k;
    k = '0;
    for (int b = 0; b < 4; b++) begin
      k[2*b]   = scan[8*b];
      k[2*b+1] = scan[8*b+4];
    end
    return k;
  endfunction

endpackage

// File: rtl/tm1638_half_tick.sv
// Half-period tick generator for the TM1638 serial clock: pulses tick every HALF
// clock_in cycles; a synchronous clear restarts the period from zero.
module tm1638_half_tick #(
  parameter int HALF = 33
) (
  input  logic clock_in,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends the read-keys command, releases DIO, clocks in the
// four scan bytes and presents the raw bits plus the decoded 8-key row.
module tm1638_key_reader
  import tm1638_key_reader_pkg::*;
#(
  parameter int CLOCK_MAX   = DEF_CLOCK_MAX,
  parameter int CLOCK_SPEED = DEF_CLOCK_SPEED,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [SCAN_BITS-1:0] raw_keys,
  output logic [7:0]           keys,
  output logic                 tm_stb,
  output logic                 tm_clk,
  output logic                 dio_out,
  output logic                 dio_oe,
  input  logic                 dio_in
);

  localparam int HALF   = CLOCK_MAX / CLOCK_SPEED / 2;
  localparam int BIT_W  = $clog2(SCAN_BITS);
  localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);

  localparam logic [BIT_W-1:0]  CMD_LAST  = BIT_W'(CMD_BITS - 1);
  localparam logic [BIT_W-1:0]  SCAN_LAST = BIT_W'(SCAN_BITS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

  state_t state, state_next;

  logic [BIT_W-1:0]     bit_cnt, bit_cnt_next, bit_inc;
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_next;
  logic [SCAN_BITS-1:0] shift_reg, shift_next;
  logic [SCAN_BITS-1:0] raw_next;
  logic [7:0]           keys_next;
  logic                 stb_next, clk_next, dout_next, oe_next;
  logic                 busy_next, done_next;
  logic                 tick, tick_clear;

  assign bit_inc = bit_cnt + 1'b1;

  tm1638_half_tick #(
    .HALF(HALF)
  ) u_half_tick (
    .clock_in(clock_in),
    .reset   (reset),
    .clear   (tick_clear),
    .tick    (tick)
  );

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      shift_reg <= '0;
      raw_keys  <= '0;
      keys      <= '0;
      tm_stb    <= 1'b1;
      tm_clk    <= 1'b1;
      dio_out   <= 1'b1;
      dio_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      wait_cnt  <= wait_cnt_next;
      shift_reg <= shift_next;
      raw_keys  <= raw_next;
      keys      <= keys_next;
      tm_stb    <= stb_next;
      tm_clk    <= clk_next;
      dio_out   <= dout_next;
      dio_oe    <= oe_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Every CLK edge lands on a half-tick except the first READ fall, which is
  // timed by the WAIT counter and restarts the half-period at the same edge.
  always_comb begin
    state_next    = state;
    bit_cnt_next  = bit_cnt;
    wait_cnt_next = wait_cnt;
    shift_next    = shift_reg;
    raw_next      = raw_keys;
    keys_next     = keys;
    stb_next      = tm_stb;
    clk_next      = tm_clk;
    dout_next     = dio_out;
    oe_next       = dio_oe;
    busy_next     = busy;
    done_next     = 1'b0;
    tick_clear    = 1'b0;

    case (state)
      ST_IDLE: begin
        stb_next = 1'b1;
        clk_next = 1'b1;
        oe_next  = 1'b0;
        if (start) begin
          state_next = ST_STB_SETUP;
          stb_next   = 1'b0;
          busy_next  = 1'b1;
          tick_clear = 1'b1;
        end
      end

      ST_STB_SETUP: begin
        if (tick) begin
          state_next   = ST_CMD;
          clk_next     = 1'b0;
          dout_next    = CMD_READ_KEYS[0];
          oe_next      = 1'b1;
          bit_cnt_next = '0;
        end
      end

      ST_CMD: begin
        if (tick) begin
          if (!tm_clk) begin
            clk_next = 1'b1;
          end else if (bit_cnt == CMD_LAST) begin
            state_next    = ST_WAIT;
            oe_next       = 1'b0;
            wait_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_inc;
            clk_next     = 1'b0;
            dout_next    = CMD_READ_KEYS[bit_inc[2:0]];
          end
        end
      end

      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next   = ST_READ;
          tick_clear   = 1'b1;
          clk_next     = 1'b0;
          bit_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end

      ST_READ: begin
        if (tick) begin
          if (!tm_clk) begin
            clk_next   = 1'b1;
            shift_next = {dio_in, shift_reg[SCAN_BITS-1:1]};
          end else if (bit_cnt == SCAN_LAST) begin
            state_next = ST_END;
            stb_next   = 1'b1;
          end else begin
            bit_cnt_next = bit_inc;
            clk_next     = 1'b0;
          end
        end
      end

      ST_END: begin
        if (tick) begin
          state_next = ST_GAP;
        end
      end

      ST_GAP: begin
        if (tick) begin
          state_next = ST_IDLE;
          raw_next   = shift_reg;
          keys_next  = decode_keys(shift_reg);
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Self-checking bench for tm1638_key_reader: a TM1638 responder model on the link
// decodes the command and returns random scan data, checked against expected frames.
module tb_tm1638_key_reader;

  localparam int CLOCK_MAX   = 20_000_000;
  localparam int CLOCK_SPEED = 300_000;
  localparam int WAIT_CYCLES = 20;
  localparam int HALF        = CLOCK_MAX / CLOCK_SPEED / 2;
  localparam int LATENCY     = (1 + 16 + 64 + 2) * HALF + WAIT_CYCLES;
  localparam int LIMIT       = 4 * LATENCY;

  logic        clock_in = 1'b0;
  logic        reset    = 1'b0;
  logic        start    = 1'b0;
  logic        busy, done;
  logic [31:0] raw_keys;
  logic [7:0]  keys;
  logic        tm_stb, tm_clk, dio_out, dio_oe;
  logic        dio_line = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // responder model state
  logic [31:0] resp_data = '0;
  logic [7:0]  cmd_byte  = '0;
  int cmd_cnt = 0, read_rises = 0, read_idx = 0, last_cmd_rise = 0;
  int wait_gap = 0, oe_bad = 0, frames = 0, dones = 0;
  int rise_cycle = 0, high_len = 0;
  bit first_fall_seen = 1'b0;
  logic prev_stb = 1'b1, prev_clk = 1'b1;

  tm1638_key_reader #(
    .CLOCK_MAX  (CLOCK_MAX),
    .CLOCK_SPEED(CLOCK_SPEED),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock_in(clock_in),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .raw_keys(raw_keys),
    .keys    (keys),
    .tm_stb  (tm_stb),
    .tm_clk  (tm_clk),
    .dio_out (dio_out),
    .dio_oe  (dio_oe),
    .dio_in  (dio_line)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cycle++;

  // TM1638 as seen from the pins: latch command bits on CLK rise, and once the
  // read command is in, put the next scan bit on DIO after every CLK fall.
  always @(negedge clock_in) begin
    if (prev_stb && !tm_stb) begin
      frames++;
      cmd_cnt = 0; cmd_byte = '0; read_rises = 0; read_idx = 0; first_fall_seen = 1'b0;
      high_len = cycle - rise_cycle;
    end
    if (!prev_stb && tm_stb) begin
      rise_cycle = cycle;
      dio_line = 1'b1;
    end
    if (!tm_stb && !prev_clk && tm_clk) begin
      if (cmd_cnt < 8) begin
        cmd_byte[cmd_cnt] = dio_oe ? dio_out : 1'b1;
        cmd_cnt++;
        last_cmd_rise = cycle;
      end else begin
        read_rises++;
      end
    end
    if (!tm_stb && prev_clk && !tm_clk && cmd_cnt == 8) begin
      if (!first_fall_seen) begin
        wait_gap = cycle - last_cmd_rise;
        first_fall_seen = 1'b1;
      end
      dio_line = (cmd_byte == 8'h42 && read_idx < 32) ? resp_data[read_idx] : 1'b1;
      read_idx++;
    end
    if (!tm_stb && cmd_cnt == 8 && (cycle - last_cmd_rise) >= HALF && dio_oe) oe_bad++;
    if (done) dones++;
    prev_stb = tm_stb;
    prev_clk = tm_clk;
  end

  // Key n sits in byte n/2, at bit 0 for even n and bit 4 for odd n.
  function automatic logic [7:0] expect_keys(input logic [31:0] d);
    logic [7:0] k;
    k = '0;
    for (int n = 0; n < 8; n++) k[n] = d[8 * (n / 2) + 4 * (n % 2)];
    return k;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus();
    @(negedge clock_in);
    start = 1'b1;
    @(negedge clock_in);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < LIMIT && !seen; n++) begin
      @(negedge clock_in);
      if (done) seen = 1'b1;
    end
    check_output({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] data, input int t0,
                             input int oe_bad0);
    logic [31:0] exp_raw;
    exp_raw = (cmd_byte == 8'h42) ? data : 32'hFFFF_FFFF;
    check_output({tag, "_latency"}, 32'(cycle - t0), 32'(LATENCY));
    check_output({tag, "_cmd"}, 32'(cmd_byte), 32'h42);
    check_output({tag, "_raw"}, raw_keys, exp_raw);
    check_output({tag, "_keys"}, 32'(keys), 32'(expect_keys(exp_raw)));
    check_output({tag, "_read_rises"}, 32'(read_rises), 32'd32);
    check_output({tag, "_wait_gap_ok"}, 32'(wait_gap >= WAIT_CYCLES), 32'd1);
    check_output({tag, "_oe_released"}, 32'(oe_bad - oe_bad0), 32'd0);
    check_output({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] data);
    int t0, ob0;
    resp_data = data;
    ob0 = oe_bad;
    apply_stimulus();
    t0 = cycle;
    check_output({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag);
    check_frame(tag, data, t0, ob0);
    @(negedge clock_in);
    check_output({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_stb"}, 32'(tm_stb), 32'd1);
    check_output({tag, "_clk"}, 32'(tm_clk), 32'd1);
    check_output({tag, "_oe"}, 32'(dio_oe), 32'd0);
    check_output({tag, "_dout"}, 32'(dio_out), 32'd1);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_raw"}, raw_keys, 32'd0);
    check_output({tag, "_keys"}, 32'(keys), 32'd0);
  endtask

  initial begin
    int t0, t1, f0, d0, ob0;
    logic [31:0] d1, d2, prev_raw;
    bit reached;

    $display("[TB] tm1638_key_reader bench, HALF=%0d latency=%0d", HALF, LATENCY);
    repeat (5) @(negedge clock_in);
    reset = 1'b1;
    repeat (100) @(negedge clock_in);
    check_reset_values("idle");

    run_frame("fixed", 32'hA50F_1180);
    for (int i = 0; i < 4; i++) run_frame($sformatf("rand%0d", i), $urandom);

    // second start while busy must be ignored
    prev_raw = raw_keys;
    d1 = $urandom;
    resp_data = d1;
    f0 = frames;
    d0 = dones;
    ob0 = oe_bad;
    apply_stimulus();
    t0 = cycle;
    repeat (500) @(negedge clock_in);
    check_output("busy_hold_raw", raw_keys, prev_raw);
    apply_stimulus();
    check_output("busy_second_start", 32'(busy), 32'd1);
    wait_done("busy");
    check_frame("busy", d1, t0, ob0);
    repeat (100) @(negedge clock_in);
    check_output("busy_frames", 32'(frames - f0), 32'd1);
    check_output("busy_dones", 32'(dones - d0), 32'd1);

    // start held across done gives back-to-back frames
    d1 = $urandom;
    d2 = $urandom;
    resp_data = d1;
    ob0 = oe_bad;
    @(negedge clock_in);
    start = 1'b1;
    @(negedge clock_in);
    t0 = cycle;
    wait_done("b2b1");
    check_frame("b2b1", d1, t0, ob0);
    resp_data = d2;
    ob0 = oe_bad;
    @(negedge clock_in);
    start = 1'b0;
    t1 = cycle;
    wait_done("b2b2");
    check_frame("b2b2", d2, t1, ob0);
    // END and GAP halves, plus the IDLE done cycle before the next accept edge
    check_output("b2b_stb_high", 32'(high_len), 32'(2 * HALF + 1));

    // reset in the middle of READ bit 10
    resp_data = $urandom;
    apply_stimulus();
    reached = 1'b0;
    for (int n = 0; n < LIMIT && !reached; n++) begin
      @(negedge clock_in);
      if (read_idx >= 11) reached = 1'b1;
    end
    check_output("midreset_reached_bit10", 32'(reached), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clock_in);
    reset = 1'b1;
    repeat (10) @(negedge clock_in);
    run_frame("after_reset", $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
